// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// wb_queue : in-order register write-back queue with pending-write lookup
// Revision  : 1.0
// ============================================================================
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    input  logic          hold,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    input  logic [4:0]    rs_addr,
    output logic          rs_hit,
    output logic [31:0]   rs_data,
    input  logic [4:0]    rt_addr,
    output logic          rt_hit,
    output logic [31:0]   rt_data,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    assign in_ready = (count != FULL_COUNT);
    assign empty    = (count == '0);
    // Writes to r0 complete the handshake but are never queued.
    assign push     = in_valid && in_ready && (in_addr != 5'd0);
    assign pop      = !empty && !hold;

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[wr_ptr] <= in_addr;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rf_we    <= 1'b1;
                rf_waddr <= q_addr[rd_ptr];
                rf_wdata <= q_data[rd_ptr];
            end else begin
                rf_we    <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to newest so the newest matching entry wins; the output
    // stage is checked first and therefore has the lowest priority.
    always_comb begin
        logic [AW-1:0] idx;
        idx     = '0;
        rs_hit  = 1'b0;
        rs_data = 32'd0;
        rt_hit  = 1'b0;
        rt_data = 32'd0;
        if (rf_we && (rf_waddr == rs_addr)) begin
            rs_hit  = 1'b1;
            rs_data = rf_wdata;
        end
        if (rf_we && (rf_waddr == rt_addr)) begin
            rt_hit  = 1'b1;
            rt_data = rf_wdata;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + k[AW-1:0];
            if ((AW+1)'(k) < count) begin
                if (q_addr[idx] == rs_addr) begin
                    rs_hit  = 1'b1;
                    rs_data = q_data[idx];
                end
                if (q_addr[idx] == rt_addr) begin
                    rt_hit  = 1'b1;
                    rt_data = q_data[idx];
                end
            end
        end
        if (rs_addr == 5'd0) begin
            rs_hit  = 1'b0;
            rs_data = 32'd0;
        end
        if (rt_addr == 5'd0) begin
            rt_hit  = 1'b0;
            rt_data = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// tb_wb_queue : directed + randomized checks of wb_queue against a queue model
// Revision    : 1.0
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_addr = 5'd0;
    logic [31:0]   in_data = 32'd0;
    logic          hold = 1'b0;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [4:0]    rs_addr = 5'd0;
    logic          rs_hit;
    logic [31:0]   rs_data;
    logic [4:0]    rt_addr = 5'd0;
    logic          rt_hit;
    logic [31:0]   rt_data;
    logic [AW:0]   count;
    logic          empty;

    wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .hold(hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs_addr(rs_addr), .rs_hit(rs_hit), .rs_data(rs_data),
        .rt_addr(rt_addr), .rt_hit(rt_hit), .rt_data(rt_data),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: pending writes as a FIFO of {addr,data}, plus output stage.
    logic [36:0] mq[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_lookup(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][36:32] == a) return {1'b1, mq[i][31:0]};
        if (m_we && m_waddr == a) return {1'b1, m_wdata};
        return 33'd0;
    endfunction

    task automatic check_all();
        logic [32:0] rs_exp, rt_exp;
        rs_exp = model_lookup(rs_addr);
        rt_exp = model_lookup(rt_addr);
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("empty",    32'(empty),    32'(mq.size() == 0));
        chk("count",    32'(count),    32'(mq.size()));
        chk("rf_we",    32'(rf_we),    32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rf_wdata", rf_wdata,      m_wdata);
        chk("rs_hit",   32'(rs_hit),   32'(rs_exp[32]));
        chk("rs_data",  rs_data,       rs_exp[31:0]);
        chk("rt_hit",   32'(rt_hit),   32'(rt_exp[32]));
        chk("rt_data",  rt_data,       rt_exp[31:0]);
    endtask

    task automatic model_clock(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h);
        logic acc;
        acc = v && (mq.size() != DEPTH);
        if (mq.size() != 0 && !h) begin
            m_we    = 1'b1;
            m_waddr = mq[0][36:32];
            m_wdata = mq[0][31:0];
            void'(mq.pop_front());
        end else begin
            m_we = 1'b0;
        end
        if (acc && a != 5'd0) mq.push_back({a, d});
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    endtask

    // Called at a negedge; applies inputs, compares, advances one clock, ends at next negedge.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic [4:0] rs, input logic [4:0] rt);
        in_valid = v; in_addr = a; in_data = d; hold = h; rs_addr = rs; rt_addr = rt;
        #1;
        check_all();
        @(posedge clock);
        model_clock(v, a, d, h);
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset empty",    32'(empty),    32'd1);
        chk("reset rs_hit",   32'(rs_hit),   32'd0);

        // Single push and drain latency
        step(1, 5'd5, 32'h1234, 0, 5'd5, 5'd0);
        chk("t1 count", 32'(count), 32'd1);
        step(0, 5'd0, 32'h0, 0, 5'd5, 5'd0);
        chk("t1 rf_we", 32'(rf_we), 32'd1);
        chk("t1 waddr", 32'(rf_waddr), 32'd5);
        chk("t1 wdata", rf_wdata, 32'h1234);
        chk("t1 count0", 32'(count), 32'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t1 rf_we0", 32'(rf_we), 32'd0);

        // Fill under hold, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 'h11), 1, 5'd0, 5'd0);
        chk("t2 count4", 32'(count), 32'd4);
        chk("t2 ready0", 32'(in_ready), 32'd0);
        step(1, 5'd5, 32'h55, 1, 5'd0, 5'd0);
        chk("t2 held", 32'(count), 32'd4);
        step(1, 5'd5, 32'h55, 0, 5'd0, 5'd0);
        chk("t2 a1", 32'(rf_waddr), 32'd1);
        chk("t2 c3", 32'(count), 32'd3);
        step(1, 5'd5, 32'h55, 0, 5'd0, 5'd0);
        chk("t2 a2", 32'(rf_waddr), 32'd2);
        chk("t2 c3b", 32'(count), 32'd3);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t2 a3", 32'(rf_waddr), 32'd3);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t2 a4", 32'(rf_waddr), 32'd4);
        chk("t2 we4", 32'(rf_we), 32'd1);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t2 a5", 32'(rf_waddr), 32'd5);
        chk("t2 d5", rf_wdata, 32'h55);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);

        // Newest-wins lookup
        step(1, 5'd7, 32'hAAAA0000, 1, 5'd7, 5'd8);
        step(1, 5'd7, 32'hBBBB0000, 1, 5'd7, 5'd8);
        chk("t3 rs_hit", 32'(rs_hit), 32'd1);
        chk("t3 rs_data", rs_data, 32'hBBBB0000);
        chk("t3 rt_hit", 32'(rt_hit), 32'd0);
        chk("t3 rt_data", rt_data, 32'd0);
        step(0, 5'd0, 32'h0, 0, 5'd7, 5'd8);
        chk("t3 drained", rf_wdata, 32'hAAAA0000);
        chk("t3 rs_data2", rs_data, 32'hBBBB0000);
        step(0, 5'd0, 32'h0, 0, 5'd7, 5'd8);
        chk("t3 outstage", rs_data, 32'hBBBB0000);
        step(0, 5'd0, 32'h0, 0, 5'd7, 5'd8);
        chk("t3 gone", 32'(rs_hit), 32'd0);

        // Write to r0
        step(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 5'd0);
        chk("t4 count", 32'(count), 32'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t4 no_we", 32'(rf_we), 32'd0);
        chk("t4 rs0", 32'(rs_hit), 32'd0);

        // Full queue with draining edge
        for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'(i), 1, 5'd0, 5'd0);
        step(1, 5'd9, 32'h99, 0, 5'd0, 5'd0);
        chk("t5 c3", 32'(count), 32'd3);
        step(1, 5'd9, 32'h99, 0, 5'd0, 5'd0);
        chk("t5 c3b", 32'(count), 32'd3);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("t5 last", 32'(rf_waddr), 32'd9);
        chk("t5 lastd", rf_wdata, 32'h99);
        step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) step(1, 5'(20 + i), 32'(i + 100), 1, 5'd21, 5'd0);
        step(0, 5'd0, 32'h0, 0, 5'd21, 5'd0);
        chk("t6 we", 32'(rf_we), 32'd1);
        chk("t6 c2", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 rst we", 32'(rf_we), 32'd0);
        chk("t6 rst count", 32'(count), 32'd0);
        chk("t6 rst hit", 32'(rs_hit), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 0, 5'd21, 5'd20);
        chk("t6 no stale", 32'(rf_we), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 ($urandom % 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
